// File: rtl/hazard_fwd_ctrl_v_if.sv
// Decode-to-hazard-unit bus for hazard_fwd_ctrl_v.
// Carries the ID-stage instruction fields and the flush request into the unit.
// Carries the stall and EX operand-select outputs back to the pipeline.
interface hazard_fwd_ctrl_v_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  flush;
    logic                  stall;
    logic [1:0]            forwA;
    logic [1:0]            forwB;
    logic                  isForw_ON;

    // Pipeline/decode side
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, flush,
        input  stall, forwA, forwB, isForw_ON
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, flush,
        output stall, forwA, forwB, isForw_ON
    );
endinterface

// File: rtl/hazard_fwd_ctrl_v.sv
// hazard_fwd_ctrl_v: EX-stage forwarding select and load-use stall generator.
// Shadows rd/regwrite of the instructions in EX, MEM and WB to detect RAW hazards.
// Optional macro FWD_EN: when defined, forwarding is enabled and only load-use stalls.
// When undefined, the unit stalls until the producer has left WB, and the selects stay 00.
module hazard_fwd_ctrl_v #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_fwd_ctrl_v_if.slave   bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } shadow_t;

    shadow_t s_ex, s_mem, id_slot;
    logic    stall_int;
    logic    bubble;

    // A stage produces r when it holds a valid writer of r; x0 is never a hazard source.
    function automatic logic match(shadow_t s, logic [REG_ADDR_W-1:0] r, logic en);
        return en & s.valid & s.regwrite & (s.rd == r) & (r != '0);
    endfunction

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    assign hit_ex_a  = match(s_ex,  bus.id_rs1, bus.id_use_rs1);
    assign hit_ex_b  = match(s_ex,  bus.id_rs2, bus.id_use_rs2);
    assign hit_mem_a = match(s_mem, bus.id_rs1, bus.id_use_rs1);
    assign hit_mem_b = match(s_mem, bus.id_rs2, bus.id_use_rs2);

    assign bubble      = bus.flush | stall_int;
    assign id_slot     = '{valid: bus.id_valid & ~bubble, rd: bus.id_rd, regwrite: bus.id_regwrite};
    assign bus.stall   = stall_int;

    // Shadow pipeline advances every cycle; a killed or stalled ID slot enters EX as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ex  <= '0;
            s_mem <= '0;
        end else begin
            s_mem <= s_ex;
            s_ex  <= id_slot;
        end
    end

`ifdef FWD_EN
    logic       ex_memread;
    logic [1:0] forw_a, forw_b, forw_a_nxt, forw_b_nxt;

    // Only a load still sitting in EX cannot be forwarded in time.
    assign stall_int = bus.id_valid & ~bus.flush & s_ex.valid & ex_memread &
                       (hit_ex_a | hit_ex_b);

    // Youngest producer (EX) takes priority over the older one (MEM).
    always_comb begin
        forw_a_nxt = 2'b00;
        forw_b_nxt = 2'b00;
        if (hit_ex_a)       forw_a_nxt = 2'b10;
        else if (hit_mem_a) forw_a_nxt = 2'b01;
        if (hit_ex_b)       forw_b_nxt = 2'b10;
        else if (hit_mem_b) forw_b_nxt = 2'b01;
    end

    // Selects travel with the instruction into EX; bubbles and empty slots read the regfile.
    always_ff @(posedge clk) begin
        if (rst || bubble || !bus.id_valid) begin
            forw_a     <= 2'b00;
            forw_b     <= 2'b00;
            ex_memread <= 1'b0;
        end else begin
            forw_a     <= forw_a_nxt;
            forw_b     <= forw_b_nxt;
            ex_memread <= bus.id_memread;
        end
    end

    assign bus.forwA     = forw_a;
    assign bus.forwB     = forw_b;
    assign bus.isForw_ON = 1'b1;
`else
    // Without forwarding a producer must leave WB before its value is readable.
    shadow_t s_wb;
    logic    hit_wb_a, hit_wb_b;

    assign hit_wb_a  = match(s_wb, bus.id_rs1, bus.id_use_rs1);
    assign hit_wb_b  = match(s_wb, bus.id_rs2, bus.id_use_rs2);
    assign stall_int = bus.id_valid & ~bus.flush &
                       (hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b | hit_wb_a | hit_wb_b);

    // WB shadow is needed only to hold the stall for the last hazard cycle.
    always_ff @(posedge clk) begin
        if (rst) s_wb <= '0;
        else     s_wb <= s_mem;
    end

    assign bus.forwA     = 2'b00;
    assign bus.forwB     = 2'b00;
    assign bus.isForw_ON = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl_v.sv
// Directed bench for hazard_fwd_ctrl_v; expectations follow the FWD_EN build setting.
module tb_hazard_fwd_ctrl_v;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    hazard_fwd_ctrl_v_if #(.REG_ADDR_W(5)) bus ();
    hazard_fwd_ctrl_v #(.REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // valid, rs1, rs2, use1, use2, rd, regwrite, memread, flush
    task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit fl);
        bus.id_valid    = v;
        bus.id_rs1      = rs1[4:0];
        bus.id_rs2      = rs2[4:0];
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.id_rd       = rd[4:0];
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.flush       = fl;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        nop();
        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("idle_stall", 8'(bus.stall), 8'h0);
            chk("idle_fwa", 8'(bus.forwA), 8'h0);
            chk("idle_fwb", 8'(bus.forwB), 8'h0);
            tick();
        end
`ifdef FWD_EN
        chk("isforw_on", 8'(bus.isForw_ON), 8'h1);

        // add x5,x1,x2 ; add x6,x5,x1
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("b2b_stall", 8'(bus.stall), 8'h0);
        tick();
        chk("b2b_fwa", 8'(bus.forwA), 8'h2);
        chk("b2b_fwb", 8'(bus.forwB), 8'h0);
        drain();

        // add x5 ; nop ; sub x7,x1,x5
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        nop(); tick();
        drive(1, 1, 5, 1, 1, 7, 1, 0, 0);
        chk("gap_stall", 8'(bus.stall), 8'h0);
        tick();
        chk("gap_fwa", 8'(bus.forwA), 8'h0);
        chk("gap_fwb", 8'(bus.forwB), 8'h1);
        // add x0 producer ; add x8,x0,x0
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 8, 1, 0, 0); tick();
        chk("x0_fwa", 8'(bus.forwA), 8'h0);
        chk("x0_fwb", 8'(bus.forwB), 8'h0);
        drain();

        // lw x3 ; add x4,x3,x3
        drive(1, 2, 0, 1, 0, 3, 1, 1, 0);
        chk("lw_nostall", 8'(bus.stall), 8'h0);
        tick();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
        chk("lu_stall1", 8'(bus.stall), 8'h1);
        tick();
        chk("lu_bub_fwa", 8'(bus.forwA), 8'h0);
        chk("lu_bub_fwb", 8'(bus.forwB), 8'h0);
        chk("lu_stall2", 8'(bus.stall), 8'h0);
        tick();
        chk("lu_fwa", 8'(bus.forwA), 8'h1);
        chk("lu_fwb", 8'(bus.forwB), 8'h1);
        drain();

        // lw x3 ; dependent add killed by flush
        drive(1, 2, 0, 1, 0, 3, 1, 1, 0); tick();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 1);
        chk("fl_stall", 8'(bus.stall), 8'h0);
        tick();
        chk("fl_fwa", 8'(bus.forwA), 8'h0);
        chk("fl_fwb", 8'(bus.forwB), 8'h0);
        drive(1, 3, 4, 1, 1, 9, 1, 0, 0);
        chk("fl_after_stall", 8'(bus.stall), 8'h0);
        tick();
        chk("fl_after_fwa", 8'(bus.forwA), 8'h1);
        chk("fl_killed_fwb", 8'(bus.forwB), 8'h0);
        drain();

        // Two writers of x5 in flight: EX one wins
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 5, 5, 1, 1, 6, 1, 0, 0); tick();
        chk("young_fwa", 8'(bus.forwA), 8'h2);
        chk("young_fwb", 8'(bus.forwB), 8'h2);
        drain();

        // use_rs gating and invalid slot
        drive(1, 1, 2, 1, 1, 5, 1, 1, 0); tick();
        drive(1, 5, 5, 0, 0, 6, 1, 0, 0);
        chk("nouse_stall", 8'(bus.stall), 8'h0);
        drive(0, 5, 5, 1, 1, 6, 1, 0, 0);
        chk("inval_stall", 8'(bus.stall), 8'h0);
        tick();
        chk("inval_fwa", 8'(bus.forwA), 8'h0);
        drain();

        // Reset mid-operation forgets the producer
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        rst = 1'b1;
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0); tick();
        rst = 1'b0;
        chk("rst_fwa", 8'(bus.forwA), 8'h0);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("rst_stall", 8'(bus.stall), 8'h0);
        tick();
        chk("rst_fwa2", 8'(bus.forwA), 8'h0);
        drain();
`else
        chk("isforw_off", 8'(bus.isForw_ON), 8'h0);

        // add x5 ; add x6,x5,x1 -> three stall cycles
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
        chk("nf_prod_stall", 8'(bus.stall), 8'h0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("nf_stall_ex", 8'(bus.stall), 8'h1);
        tick();
        chk("nf_fwa", 8'(bus.forwA), 8'h0);
        chk("nf_stall_mem", 8'(bus.stall), 8'h1);
        tick();
        chk("nf_stall_wb", 8'(bus.stall), 8'h1);
        tick();
        chk("nf_stall_done", 8'(bus.stall), 8'h0);
        tick();
        chk("nf_fwa2", 8'(bus.forwA), 8'h0);
        chk("nf_fwb2", 8'(bus.forwB), 8'h0);
        drain();

        // Load on rs2 behaves the same
        drive(1, 2, 0, 1, 0, 3, 1, 1, 0); tick();
        drive(1, 1, 3, 1, 1, 4, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("nf_lu_stall", 8'(bus.stall), 8'h1);
            tick();
        end
        chk("nf_lu_done", 8'(bus.stall), 8'h0);
        drain();

        // Flush suppresses the stall and kills the consumer
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        drive(1, 5, 5, 1, 1, 6, 1, 0, 1);
        chk("nf_flush", 8'(bus.stall), 8'h0);
        tick();
        drive(1, 5, 6, 1, 1, 7, 1, 0, 0);
        chk("nf_post_flush", 8'(bus.stall), 8'h1);
        drain();

        // x0 writer, unused sources, invalid slot, non-writer
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 8, 1, 0, 0);
        chk("nf_x0", 8'(bus.stall), 8'h0);
        drain();
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        drive(1, 5, 5, 0, 0, 6, 1, 0, 0);
        chk("nf_nouse", 8'(bus.stall), 8'h0);
        drive(0, 5, 5, 1, 1, 6, 1, 0, 0);
        chk("nf_inval", 8'(bus.stall), 8'h0);
        drain();
        drive(1, 1, 2, 1, 1, 5, 0, 0, 0); tick();
        drive(1, 5, 5, 1, 1, 6, 1, 0, 0);
        chk("nf_norw", 8'(bus.stall), 8'h0);
        drain();

        // Reset mid-operation forgets the producer
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
        rst = 1'b1;
        nop(); tick();
        rst = 1'b0;
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("nf_rst_stall", 8'(bus.stall), 8'h0);
        drain();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
